// File: rtl/clint_ctrl_if.sv
// clint_ctrl_if: bundle between ID/EX, the CSR file and clint_ctrl.
// slave = controller side, master = pipeline/CSR side.
interface clint_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ecall;
  logic              inst_ebreak;
  logic              inst_mret;
  logic              ex_jump_flag;
  logic [ADDR_W-1:0] ex_jump_addr;
  logic              ex_csr_we;
  logic              irq_ext;
  logic              irq_tmr;
  logic [DATA_W-1:0] csr_mtvec;
  logic [DATA_W-1:0] csr_mepc;
  logic [DATA_W-1:0] csr_mstatus;
  logic              global_int_en;
  logic              int_we;
  logic [ADDR_W-1:0] int_waddr;
  logic [ADDR_W-1:0] int_raddr;
  logic [DATA_W-1:0] int_wdata;
  logic              hold_flag;
  logic              int_assert;
  logic [ADDR_W-1:0] int_addr;

  modport slave (
    input  inst_pc, inst_ecall, inst_ebreak, inst_mret,
    input  ex_jump_flag, ex_jump_addr, ex_csr_we,
    input  irq_ext, irq_tmr,
    input  csr_mtvec, csr_mepc, csr_mstatus,
    input  global_int_en,
    output int_we, int_waddr, int_raddr, int_wdata,
    output hold_flag, int_assert, int_addr
  );

  modport master (
    output inst_pc, inst_ecall, inst_ebreak, inst_mret,
    output ex_jump_flag, ex_jump_addr, ex_csr_we,
    output irq_ext, irq_tmr,
    output csr_mtvec, csr_mepc, csr_mstatus,
    output global_int_en,
    input  int_we, int_waddr, int_raddr, int_wdata,
    input  hold_flag, int_assert, int_addr
  );
endinterface

// File: rtl/clint_ctrl.sv
// clint_ctrl: core-local trap/interrupt sequencer feeding the CSR int_* port.
// Define CLINT_VECTORED_EN to enable vectored mtvec mode for interrupts.
module clint_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  clint_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MCAUSE,
    S_MSTATUS,
    S_MRET,
    S_ASSERT
  } state_t;

  localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(12'h342);

  localparam logic [DATA_W-1:0] C_ECALL  = DATA_W'(4'hB);
  localparam logic [DATA_W-1:0] C_EBREAK = DATA_W'(4'h3);
  localparam logic [DATA_W-1:0] C_EXT    = {1'b1, (DATA_W-1)'(4'hB)};
  localparam logic [DATA_W-1:0] C_TMR    = {1'b1, (DATA_W-1)'(4'h7)};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              mret_q, mret_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              hold;
  logic              strobe;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] trap_tgt;
  logic [ADDR_W-1:0] irq_epc;

  logic sel_ecall, sel_ebreak, sel_mret;
  logic sel_ext, sel_tmr;
  logic req, acc;

  // One-hot priority select: ecall > ebreak > mret > ext > tmr
  always_comb begin
    sel_ecall  = bus.inst_ecall;
    sel_ebreak = !bus.inst_ecall && bus.inst_ebreak;
    sel_mret   = !bus.inst_ecall && !bus.inst_ebreak
                 && bus.inst_mret;
    sel_ext    = !bus.inst_ecall && !bus.inst_ebreak
                 && !bus.inst_mret
                 && bus.global_int_en && bus.irq_ext;
    sel_tmr    = !bus.inst_ecall && !bus.inst_ebreak
                 && !bus.inst_mret
                 && bus.global_int_en && !bus.irq_ext
                 && bus.irq_tmr;
    req = sel_ecall | sel_ebreak | sel_mret
        | sel_ext | sel_tmr;
    acc = rst_n && (state_q == S_IDLE)
        && !bus.ex_csr_we && req;
  end

  // Trap vector: base, plus cause offset for vectored interrupts
  always_comb begin
    trap_tgt = {bus.csr_mtvec[ADDR_W-1:2], 2'b00};
`ifdef CLINT_VECTORED_EN
    if (bus.csr_mtvec[0] && cause_q[DATA_W-1])
      trap_tgt = trap_tgt
               + ADDR_W'({cause_q[3:0], 2'b00});
`endif
    irq_epc = bus.ex_jump_flag ? bus.ex_jump_addr
                               : bus.inst_pc;
  end

  // State and latched trap context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      mret_q  <= mret_d;
    end
  end

  // Next state and CSR write / redirect outputs
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    mret_d  = mret_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    hold    = 1'b0;
    strobe  = 1'b0;
    target  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          hold   = 1'b1;
          mret_d = 1'b0;
          unique case (1'b1)
            sel_ecall: begin
              cause_d = C_ECALL;
              epc_d   = bus.inst_pc;
              state_d = S_MEPC;
            end
            sel_ebreak: begin
              cause_d = C_EBREAK;
              epc_d   = bus.inst_pc;
              state_d = S_MEPC;
            end
            sel_mret: begin
              mret_d  = 1'b1;
              state_d = S_MRET;
            end
            sel_ext: begin
              cause_d = C_EXT;
              epc_d   = irq_epc;
              state_d = S_MEPC;
            end
            sel_tmr: begin
              cause_d = C_TMR;
              epc_d   = irq_epc;
              state_d = S_MEPC;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_MEPC: begin
        hold    = 1'b1;
        we      = 1'b1;
        waddr   = A_MEPC;
        wdata   = DATA_W'(epc_q);
        state_d = S_MCAUSE;
      end
      S_MCAUSE: begin
        hold    = 1'b1;
        we      = 1'b1;
        waddr   = A_MCAUSE;
        wdata   = cause_q;
        state_d = S_MSTATUS;
      end
      S_MSTATUS: begin
        hold     = 1'b1;
        we       = 1'b1;
        waddr    = A_MSTATUS;
        wdata    = bus.csr_mstatus;
        wdata[7] = bus.csr_mstatus[3];
        wdata[3] = 1'b0;
        state_d  = S_ASSERT;
      end
      S_MRET: begin
        hold     = 1'b1;
        we       = 1'b1;
        waddr    = A_MSTATUS;
        wdata    = bus.csr_mstatus;
        wdata[3] = bus.csr_mstatus[7];
        wdata[7] = 1'b1;
        state_d  = S_ASSERT;
      end
      S_ASSERT: begin
        hold    = 1'b1;
        strobe  = 1'b1;
        target  = mret_q ? bus.csr_mepc[ADDR_W-1:0]
                         : trap_tgt;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.int_we     = we;
  assign bus.int_waddr  = waddr;
  assign bus.int_raddr  = waddr;
  assign bus.int_wdata  = wdata;
  assign bus.hold_flag  = hold;
  assign bus.int_assert = strobe;
  assign bus.int_addr   = target;

endmodule

// File: tb/tb_clint_ctrl.sv
// tb_clint_ctrl: directed scoreboard bench for clint_ctrl.
// Honours CLINT_VECTORED_EN for the expected trap target.
module tb_clint_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] wq[$];
  logic [15:0] tq[$];

  clint_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  clint_ctrl #(.DATA_W(16), .ADDR_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tgt(
    input logic [15:0] mtv,
    input logic [15:0] cause);
    logic [15:0] t;
    t = {mtv[15:2], 2'b00};
`ifdef CLINT_VECTORED_EN
    if (mtv[0] && cause[15])
      t = t + {10'd0, cause[3:0], 2'b00};
`endif
    return t;
  endfunction

  task automatic push_trap(input logic [15:0] epc,
                           input logic [15:0] cause,
                           input logic [15:0] mst);
    wq.push_back({16'h0341, epc});
    wq.push_back({16'h0342, cause});
    wq.push_back({16'h0300, mst});
    tq.push_back(tgt(bus.csr_mtvec, cause));
  endtask

  task automatic run_seq(input int lat);
    logic [31:0] e;
    bit done;
    done = 1'b0;
    for (int c = 1; c <= 12 && !done; c++) begin
      @(negedge clk);
      chk("hold_busy", {31'd0, bus.hold_flag}, 1);
      if (bus.int_we) begin
        chk("we_expected", wq.size(), wq.size() == 0 ? 1 : wq.size());
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("csr_wr", {bus.int_waddr, bus.int_wdata}, e);
          chk("csr_raddr", {16'd0, bus.int_raddr}, {16'd0, e[31:16]});
        end
      end
      if (bus.int_assert) begin
        done = 1'b1;
        chk("latency", c, lat);
        chk("target", {16'd0, bus.int_addr},
            {16'd0, tq.size() != 0 ? tq.pop_front() : 16'hDEAD});
      end
    end
    chk("no_timeout", {31'd0, done}, 1);
    chk("writes_done", wq.size(), 0);
  endtask

  task automatic accept_cycle();
    @(negedge clk);
    chk("hold_accept", {31'd0, bus.hold_flag}, 1);
    @(posedge clk); #1;
  endtask

  task automatic next_step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inst_pc = '0;
    bus.inst_ecall = 0;
    bus.inst_ebreak = 0;
    bus.inst_mret = 0;
    bus.ex_jump_flag = 0;
    bus.ex_jump_addr = '0;
    bus.ex_csr_we = 0;
    bus.irq_ext = 0;
    bus.irq_tmr = 0;
    bus.csr_mtvec = 16'h0100;
    bus.csr_mepc = '0;
    bus.csr_mstatus = 16'h0008;
    bus.global_int_en = 0;

    bus.inst_ecall = 1;
    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, bus.int_we}, 0);
    chk("rst_hold", {31'd0, bus.hold_flag}, 0);
    chk("rst_assert", {31'd0, bus.int_assert}, 0);
    chk("rst_waddr", {16'd0, bus.int_waddr}, 0);
    chk("rst_wdata", {16'd0, bus.int_wdata}, 0);
    chk("rst_addr", {16'd0, bus.int_addr}, 0);
    bus.inst_ecall = 0;
    next_step();
    rst_n = 1'b1;
    next_step();

    // 1: ecall
    bus.inst_pc = 16'h0040;
    bus.inst_ecall = 1;
    push_trap(16'h0040, 16'h000B, 16'h0080);
    accept_cycle();
    bus.inst_ecall = 0;
    run_seq(4);

    // 2: mret back-to-back
    next_step();
    bus.csr_mstatus = 16'h0080;
    bus.csr_mepc = 16'h0044;
    bus.inst_mret = 1;
    wq.push_back({16'h0300, 16'h0088});
    tq.push_back(16'h0044);
    accept_cycle();
    bus.inst_mret = 0;
    run_seq(2);
    @(negedge clk);
    chk("hold_after_mret", {31'd0, bus.hold_flag}, 0);

    // 3: masked then enabled external irq
    next_step();
    bus.csr_mstatus = 16'h0008;
    bus.inst_pc = 16'h0050;
    bus.irq_ext = 1;
    repeat (3) begin
      @(negedge clk);
      chk("masked_hold", {31'd0, bus.hold_flag}, 0);
      chk("masked_we", {31'd0, bus.int_we}, 0);
    end
    next_step();
    bus.global_int_en = 1;
    push_trap(16'h0050, 16'h800B, 16'h0080);
    accept_cycle();
    bus.irq_ext = 0;
    run_seq(4);
    next_step();
    bus.irq_ext = 1;
    bus.ex_jump_flag = 1;
    bus.ex_jump_addr = 16'h0200;
    push_trap(16'h0200, 16'h800B, 16'h0080);
    accept_cycle();
    bus.irq_ext = 0;
    bus.ex_jump_flag = 0;
    run_seq(4);

    // 4: priority and ex_csr_we deferral
    next_step();
    bus.inst_pc = 16'h0060;
    bus.inst_ecall = 1;
    bus.irq_tmr = 1;
    push_trap(16'h0060, 16'h000B, 16'h0080);
    accept_cycle();
    bus.inst_ecall = 0;
    bus.irq_tmr = 0;
    run_seq(4);
    next_step();
    bus.inst_pc = 16'h0064;
    bus.inst_ecall = 1;
    bus.ex_csr_we = 1;
    @(negedge clk);
    chk("defer_hold", {31'd0, bus.hold_flag}, 0);
    chk("defer_we", {31'd0, bus.int_we}, 0);
    next_step();
    bus.ex_csr_we = 0;
    push_trap(16'h0064, 16'h000B, 16'h0080);
    accept_cycle();
    bus.inst_ecall = 0;
    run_seq(4);

    // 5: reset during MCAUSE
    next_step();
    bus.inst_pc = 16'h0070;
    bus.inst_ecall = 1;
    accept_cycle();
    bus.inst_ecall = 0;
    @(negedge clk);
    chk("abort_mepc", {bus.int_waddr, bus.int_wdata},
        {16'h0341, 16'h0070});
    next_step();
    chk("abort_mcause", {bus.int_waddr, bus.int_wdata},
        {16'h0342, 16'h000B});
    rst_n = 1'b0;
    #1;
    chk("abort_we", {31'd0, bus.int_we}, 0);
    chk("abort_hold", {31'd0, bus.hold_flag}, 0);
    chk("abort_waddr", {16'd0, bus.int_waddr}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_assert", {31'd0, bus.int_assert}, 0);
    end
    next_step();
    rst_n = 1'b1;
    next_step();
    bus.inst_pc = 16'h0074;
    bus.inst_ecall = 1;
    push_trap(16'h0074, 16'h000B, 16'h0080);
    accept_cycle();
    bus.inst_ecall = 0;
    run_seq(4);

    // 6: vectored mtvec
    next_step();
    bus.csr_mtvec = 16'h0101;
    bus.inst_pc = 16'h0080;
    bus.irq_tmr = 1;
    push_trap(16'h0080, 16'h8007, 16'h0080);
    accept_cycle();
    bus.irq_tmr = 0;
    run_seq(4);
    next_step();
    bus.inst_pc = 16'h0084;
    bus.inst_ecall = 1;
    push_trap(16'h0084, 16'h000B, 16'h0080);
    accept_cycle();
    bus.inst_ecall = 0;
    run_seq(4);
    next_step();
    bus.inst_pc = 16'h0088;
    bus.inst_ebreak = 1;
    push_trap(16'h0088, 16'h0003, 16'h0080);
    accept_cycle();
    bus.inst_ebreak = 0;
    run_seq(4);
    @(negedge clk);
    chk("idle_end", {31'd0, bus.hold_flag}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
